// File: rtl/sad_block_loader.sv
// Gathers a byte stream into a 2x2 current/reference block pair
// for the SAD datapath: 8-slot assembly buffer plus an output register.
module sad_block_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pix_in,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic        flush,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic [7:0]  A00,
  output logic [7:0]  A01,
  output logic [7:0]  A10,
  output logic [7:0]  A11,
  output logic [7:0]  B00,
  output logic [7:0]  B01,
  output logic [7:0]  B10,
  output logic [7:0]  B11,
  output logic [15:0] blk_count
);

  typedef enum logic {FILL, FULL} state_t;

  state_t     state, state_n;
  logic [2:0] idx, idx_n;
  logic [7:0] slot [8];
  logic [7:0] last;
  logic       take, xfer, load;

  assign pix_ready = (state == FILL);
  assign xfer      = blk_valid && blk_ready;
  assign take      = pix_valid && pix_ready && !flush;
  // the 8th pixel bypasses the buffer when it loads on its own edge
  assign last      = (state == FILL) ? pix_in : slot[7];

  always_comb begin
    state_n = state;
    idx_n   = idx;
    load    = 1'b0;
    unique case (state)
      FILL: begin
        if (flush) begin
          idx_n = 3'd0;
        end else if (take) begin
          if (idx == 3'd7) begin
            idx_n = 3'd0;
            if (!blk_valid || blk_ready) load = 1'b1;
            else state_n = FULL;
          end else begin
            idx_n = idx + 3'd1;
          end
        end
      end
      FULL: begin
        if (flush) begin
          state_n = FILL;
          idx_n   = 3'd0;
        end else if (xfer) begin
          state_n = FILL;
          idx_n   = 3'd0;
          load    = 1'b1;
        end
      end
      default: begin
        state_n = FILL;
        idx_n   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FILL;
      idx   <= 3'd0;
      for (int i = 0; i < 8; i++) slot[i] <= 8'd0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (take) slot[idx] <= pix_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_valid <= 1'b0;
      blk_count <= 16'd0;
      A00 <= 8'd0;
      A01 <= 8'd0;
      A10 <= 8'd0;
      A11 <= 8'd0;
      B00 <= 8'd0;
      B01 <= 8'd0;
      B10 <= 8'd0;
      B11 <= 8'd0;
    end else begin
      if (xfer) blk_count <= blk_count + 16'd1;
      if (load) begin
        blk_valid <= 1'b1;
        A00 <= slot[0];
        A01 <= slot[1];
        A10 <= slot[2];
        A11 <= slot[3];
        B00 <= slot[4];
        B01 <= slot[5];
        B10 <= slot[6];
        B11 <= last;
      end else if (xfer) begin
        blk_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sad_block_loader.sv
// Directed bench for sad_block_loader: fill, backpressure, flush,
// throughput, async reset and count wrap.
module tb_sad_block_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  pix_in = 8'd0;
  logic        pix_valid = 1'b0;
  logic        flush = 1'b0;
  logic        blk_ready = 1'b0;
  logic        pix_ready, blk_valid;
  logic [7:0]  A00, A01, A10, A11, B00, B01, B10, B11;
  logic [15:0] blk_count;

  int n_chk = 0;
  int n_err = 0;

  sad_block_loader dut (
    .clk(clk), .rst(rst),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .flush(flush),
    .blk_valid(blk_valid), .blk_ready(blk_ready),
    .A00(A00), .A01(A01), .A10(A10), .A11(A11),
    .B00(B00), .B01(B01), .B10(B10), .B11(B11),
    .blk_count(blk_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] blk();
    return {A00, A01, A10, A11, B00, B01, B10, B11};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic feed(input logic [7:0] p);
    pix_in    = p;
    pix_valid = 1'b1;
    step();
    pix_valid = 1'b0;
  endtask

  task automatic feed8(input logic [63:0] b);
    for (int i = 0; i < 8; i++) feed(b[63-8*i -: 8]);
  endtask

  localparam logic [63:0] BASIC = 64'h00010203_01020304;
  localparam logic [63:0] BP1   = 64'h01020304_00010203;
  localparam logic [63:0] BP2   = 64'hff00ff00_00ff00ff;
  localparam logic [63:0] FL0   = 64'h0a0b0c0d_0e0f1011;
  localparam logic [63:0] FL1   = 64'h30313233_34353637;
  localparam logic [63:0] RS1   = 64'h11223344_55667788;

  initial begin
    int drops;
    logic [63:0] e;
    logic [7:0]  base;

    #1;
    check("rst_valid", 64'(blk_valid), 64'd0);
    check("rst_ready", 64'(pix_ready), 64'd1);
    check("rst_blk", blk(), 64'd0);
    check("rst_count", 64'(blk_count), 64'd0);
    #15 rst = 1'b0;

    // basic fill
    blk_ready = 1'b1;
    feed8(BASIC);
    check("basic_valid", 64'(blk_valid), 64'd1);
    check("basic_blk", blk(), BASIC);
    check("basic_cnt0", 64'(blk_count), 64'd0);
    step();
    check("basic_cnt1", 64'(blk_count), 64'd1);
    check("basic_drop", 64'(blk_valid), 64'd0);

    // backpressure
    blk_ready = 1'b0;
    feed8(BP1);
    check("bp_valid", 64'(blk_valid), 64'd1);
    check("bp_ready1", 64'(pix_ready), 64'd1);
    feed8(BP2);
    check("bp_full", 64'(pix_ready), 64'd0);
    check("bp_hold", blk(), BP1);
    step();
    check("bp_hold2", blk(), BP1);
    check("bp_full2", 64'(pix_ready), 64'd0);
    blk_ready = 1'b1;
    step();
    check("bp_second", blk(), BP2);
    check("bp_valid2", 64'(blk_valid), 64'd1);
    check("bp_ready2", 64'(pix_ready), 64'd1);
    check("bp_cnt2", 64'(blk_count), 64'd2);
    step();
    check("bp_cnt3", 64'(blk_count), 64'd3);
    check("bp_empty", 64'(blk_valid), 64'd0);

    // flush
    blk_ready = 1'b0;
    feed8(FL0);
    for (int i = 0; i < 5; i++) feed(8'(8'h20 + i));
    flush     = 1'b1;
    pix_valid = 1'b1;
    pix_in    = 8'h99;
    step();
    flush     = 1'b0;
    pix_valid = 1'b0;
    check("fl_hold_blk", blk(), FL0);
    check("fl_hold_cnt", 64'(blk_count), 64'd3);
    feed8(FL1);
    check("fl_full", 64'(pix_ready), 64'd0);
    check("fl_hold_blk2", blk(), FL0);
    check("fl_hold_cnt2", 64'(blk_count), 64'd3);
    blk_ready = 1'b1;
    step();
    check("fl_new_blk", blk(), FL1);
    check("fl_cnt4", 64'(blk_count), 64'd4);
    step();
    check("fl_cnt5", 64'(blk_count), 64'd5);

    // throughput
    drops = 0;
    for (int j = 1; j <= 80; j++) begin
      if (!pix_ready) drops++;
      pix_in    = 8'(j - 1);
      pix_valid = 1'b1;
      step();
      if (j % 8 == 0) begin
        base = 8'(j - 8);
        for (int k = 0; k < 8; k++) e[63-8*k -: 8] = 8'(base + k);
        check("tp_blk", blk(), e);
        check("tp_valid", 64'(blk_valid), 64'd1);
      end
    end
    pix_valid = 1'b0;
    step();
    check("tp_drops", 64'(drops), 64'd0);
    check("tp_cnt", 64'(blk_count), 64'd15);
    check("tp_empty", 64'(blk_valid), 64'd0);

    // async reset while FULL
    blk_ready = 1'b0;
    feed8(BP1);
    feed8(BP2);
    check("ar_full", 64'(pix_ready), 64'd0);
    #3 rst = 1'b1;
    #1;
    check("ar_valid", 64'(blk_valid), 64'd0);
    check("ar_ready", 64'(pix_ready), 64'd1);
    check("ar_blk", blk(), 64'd0);
    check("ar_cnt", 64'(blk_count), 64'd0);
    #1 rst = 1'b0;
    blk_ready = 1'b1;
    feed8(RS1);
    check("ar_first_blk", blk(), RS1);
    step();
    check("ar_cnt1", 64'(blk_count), 64'd1);

    // wrap
    @(negedge clk);
    force dut.blk_count = 16'hfffe;
    #1;
    release dut.blk_count;
    check("wr_pre", 64'(blk_count), 64'hfffe);
    feed8(BASIC);
    step();
    check("wr_ffff", 64'(blk_count), 64'hffff);
    feed8(BP1);
    step();
    check("wr_zero", 64'(blk_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sad_block_loader.md
SAD_BLOCK_LOADER -- requirements
Module: sad_block_loader

Interface
REQ-001 The module SHALL have these ports, clock and reset first:
- clk  input  1  sole clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-high reset
- pix_in  input  8  pixel byte, unsigned
- pix_valid  input  1  pix_in carries a pixel this cycle
- pix_ready  output  1  loader can accept a pixel this cycle
- flush  input  1  synchronous discard of the partially assembled block
- blk_valid  output  1  A00..B11 hold a complete block
- blk_ready  input  1  downstream SAD datapath accepts the block this cycle
- A00, A01, A10, A11  output  8 each  current-block pixels
- B00, B01, B10, B11  output  8 each  reference-block pixels
- blk_count  output  16  number of blocks delivered, modulo 2^16
REQ-002 The module SHALL have no parameters; pixel width 8, block 2x2, pair size 8 pixels, all fixed.

Function
REQ-003 A pixel SHALL be accepted on a rising edge where pix_valid=1 and pix_ready=1; blocks SHALL transfer on an edge where blk_valid=1 and blk_ready=1.
REQ-004 Accepted pixels SHALL fill slots in fixed order: A00, A01, A10, A11, B00, B01, B10, B11; a 3-bit fill index SHALL track the next slot.
REQ-005 Structure SHALL be two-stage: an assembly buffer of 8 slots and an output register that drives A00..B11.
REQ-006 States SHALL be: FILL (index 0..7, accepting), FULL (8 pixels assembled, output register occupied, pix_ready=0).
REQ-007 On the edge accepting the 8th pixel, if the output register is empty or is transferring on that same edge, all 8 pixels SHALL load into the output register, blk_valid SHALL be 1 from the next cycle, and the index SHALL return to 0 in FILL.
REQ-008 On the edge accepting the 8th pixel, if the output register is occupied and not transferring, the loader SHALL enter FULL.
REQ-009 In FULL, on the edge where the output transfers, the assembled block SHALL load into the output register, blk_valid SHALL stay 1, and the state SHALL return to FILL with index 0.
REQ-010 pix_ready SHALL be 1 in FILL and 0 in FULL, combinationally independent of pix_valid.
REQ-011 A00..B11 SHALL remain stable while blk_valid=1 and blk_ready=0.
REQ-012 After a transfer with no new block loaded on that edge, blk_valid SHALL fall to 0 on the next cycle.
REQ-013 Sustained throughput SHALL be one block per 8 cycles with pix_valid=1 and blk_ready=1 held continuously.
REQ-014 blk_count SHALL increment by 1 on each block transfer and wrap from 65535 to 0.
REQ-015 flush=1 SHALL discard assembled pixels, force index 0 and FILL, and accept no pixel on that edge; the output register and blk_count SHALL be unaffected.
REQ-016 flush SHALL have priority over a simultaneous pixel acceptance and over the FULL-to-output load.
REQ-017 pix_valid=0 SHALL stall filling without loss; the index SHALL hold.

Reset
REQ-018 When rst=1, the loader SHALL immediately, without waiting for clk:
- clear the index and enter FILL
- set blk_valid=0 and pix_ready=1
- set A00..B11 to 0
- set blk_count to 0
REQ-019 Reset asserted mid-block or mid-transfer SHALL discard all buffered pixels and blocks.
REQ-020 After rst deasserts, the first rising edge SHALL be able to accept a pixel.

Verification
REQ-021 Bench SHALL cover these directed scenarios:
- Basic fill: blk_ready=1; stream 0,1,2,3,1,2,3,4 -> one cycle after the 8th accept, blk_valid=1 with A00..A11=0,1,2,3 and B00..B11=1,2,3,4; blk_count=1.
- Backpressure: blk_ready=0; stream two blocks (1,2,3,4,0,1,2,3 then 255,0,255,0,0,255,0,255) -> outputs hold the first block; pix_ready=0 after the 16th accept. Raise blk_ready -> second block appears the next cycle, then pix_ready=1.
- Flush: accept 5 pixels, pulse flush with pix_valid=1 -> that pixel is not accepted. The next 8 pixels form the block; the prior output and blk_count are unchanged until it transfers.
- Throughput: continuous valid and ready for 80 cycles -> exactly 10 transfers, blk_count=10, no pixel dropped.
- Async reset: assert rst between clock edges while in FULL -> blk_valid=0, pix_ready=1, outputs=0 and blk_count=0 immediately.
- Wrap: preload by delivering 65536 blocks -> blk_count=0.
